// File: rtl/wb_queue_if.sv
// Bundle between the writeback queue, its two result producers, the register
// file write port and the operand-fetch forwarding lookup.
interface wb_queue_if #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          alu_valid;
  logic [AW-1:0] alu_wn;
  logic [DW-1:0] alu_wd;
  logic          alu_ready;
  logic          mem_valid;
  logic [AW-1:0] mem_wn;
  logic [DW-1:0] mem_wd;
  logic          mem_ready;
  logic          RegWrite;
  logic [AW-1:0] WN;
  logic [DW-1:0] WD;
  logic [AW-1:0] fwd_rn1;
  logic [AW-1:0] fwd_rn2;
  logic          fwd_hit1;
  logic          fwd_hit2;
  logic [DW-1:0] fwd_data1;
  logic [DW-1:0] fwd_data2;
  logic [CW-1:0] count;

  modport master (
    output alu_valid, alu_wn, alu_wd, mem_valid, mem_wn, mem_wd, fwd_rn1, fwd_rn2,
    input  alu_ready, mem_ready, RegWrite, WN, WD, fwd_hit1, fwd_hit2,
           fwd_data1, fwd_data2, count
  );

  modport slave (
    input  alu_valid, alu_wn, alu_wd, mem_valid, mem_wn, mem_wd, fwd_rn1, fwd_rn2,
    output alu_ready, mem_ready, RegWrite, WN, WD, fwd_hit1, fwd_hit2,
           fwd_data1, fwd_data2, count
  );
endinterface

// File: rtl/wb_queue.sv
// Writeback FIFO merging ALU and load results onto the single register-file
// write port, with a youngest-match forwarding lookup over pending writes.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic       clk,
  input  logic       rst,
  wb_queue_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] wn_mem [DEPTH];
  logic [DW-1:0] wd_mem [DEPTH];

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          regwrite_q;
  logic [AW-1:0] wn_q;
  logic [DW-1:0] wd_q;

  logic          alu_ready, mem_ready, alu_enq, mem_enq, pop;
  logic [PW-1:0] mem_slot;

  // Readiness looks only at registered occupancy; the pop of this edge is not credited.
  assign alu_ready = (count_q != CW'(DEPTH));
  assign mem_ready = bus.alu_valid ? (count_q <= CW'(DEPTH - 2)) : alu_ready;
  assign alu_enq   = bus.alu_valid & alu_ready & (bus.alu_wn != '0);
  assign mem_enq   = bus.mem_valid & mem_ready & (bus.mem_wn != '0);
  assign pop       = (count_q != '0);
  assign mem_slot  = tail_q + PW'(alu_enq);

  always_comb begin
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(alu_enq) + PW'(mem_enq);
    count_d = count_q + CW'(alu_enq) + CW'(mem_enq) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      regwrite_q <= 1'b0;
      wn_q       <= '0;
      wd_q       <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (pop) begin
        regwrite_q <= 1'b1;
        wn_q       <= wn_mem[head_q];
        wd_q       <= wd_mem[head_q];
      end else begin
        regwrite_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alu_enq) begin
      wn_mem[tail_q] <= bus.alu_wn;
      wd_mem[tail_q] <= bus.alu_wd;
    end
    if (mem_enq) begin
      wn_mem[mem_slot] <= bus.mem_wn;
      wd_mem[mem_slot] <= bus.mem_wd;
    end
  end

  // Entries re-ordered by age: index 0 is the head (oldest).
  logic          live [DEPTH];
  logic [AW-1:0] age_wn [DEPTH];
  logic [DW-1:0] age_wd [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
    logic [PW-1:0] slot;
    assign slot       = head_q + PW'(gi);
    assign live[gi]   = (CW'(gi) < count_q);
    assign age_wn[gi] = wn_mem[slot];
    assign age_wd[gi] = wd_mem[slot];
  end

  logic [AW-1:0] rn_v   [2];
  logic [1:0]    hit_v;
  logic [DW-1:0] data_v [2];

  assign rn_v[0] = bus.fwd_rn1;
  assign rn_v[1] = bus.fwd_rn2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic          hit_g;
    logic [DW-1:0] data_g;
    // Scan oldest to youngest so the last match left standing is the youngest.
    always_comb begin
      hit_g  = 1'b0;
      data_g = '0;
      if (regwrite_q && (wn_q == rn_v[gi])) begin
        hit_g  = 1'b1;
        data_g = wd_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (live[i] && (age_wn[i] == rn_v[gi])) begin
          hit_g  = 1'b1;
          data_g = age_wd[i];
        end
      end
      if (rn_v[gi] == '0) begin
        hit_g  = 1'b0;
        data_g = '0;
      end
    end
    assign hit_v[gi]  = hit_g;
    assign data_v[gi] = data_g;
  end

  assign bus.alu_ready = alu_ready;
  assign bus.mem_ready = mem_ready;
  assign bus.RegWrite  = regwrite_q;
  assign bus.WN        = wn_q;
  assign bus.WD        = wd_q;
  assign bus.count     = count_q;
  assign bus.fwd_hit1  = hit_v[0];
  assign bus.fwd_hit2  = hit_v[1];
  assign bus.fwd_data1 = data_v[0];
  assign bus.fwd_data2 = data_v[1];
endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: vector table plus scoreboard of pending
// writes, and hand sequences for reset, pointer wrap and a full 2-deep queue.
module tb_wb_queue;
  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_queue_if #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) bus ();
  wb_queue_if #(.DEPTH(2),     .DW(DW), .AW(AW)) bus2 ();

  wb_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut  (.clk(clk), .rst(rst), .bus(bus));
  wb_queue #(.DEPTH(2),     .DW(DW), .AW(AW)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct {
    logic [AW-1:0] wn;
    logic [DW-1:0] wd;
  } ent_t;

  typedef struct {
    logic          av;
    logic [AW-1:0] awn;
    logic [DW-1:0] awd;
    logic          mv;
    logic [AW-1:0] mwn;
    logic [DW-1:0] mwd;
    logic [AW-1:0] rn1;
    logic [AW-1:0] rn2;
    int            ear;
    int            emr;
    int            ecnt;
  } vec_t;

  ent_t exp_q[$];
  vec_t vecs[$];
  logic last_rw = 1'b0;
  ent_t last;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   txn      = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference forwarding: youngest queued entry first, then the output register.
  function automatic void model_fwd(input logic [AW-1:0] rn, output logic hit, output logic [DW-1:0] data);
    hit  = 1'b0;
    data = '0;
    if (rn == '0) return;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].wn == rn) begin
        hit  = 1'b1;
        data = exp_q[i].wd;
        return;
      end
    end
    if (last_rw && (last.wn == rn)) begin
      hit  = 1'b1;
      data = last.wd;
    end
  endfunction

  task automatic add(input logic av, input logic [AW-1:0] awn, input logic [DW-1:0] awd,
                     input logic mv, input logic [AW-1:0] mwn, input logic [DW-1:0] mwd,
                     input logic [AW-1:0] rn1, input logic [AW-1:0] rn2,
                     input int ear, input int emr, input int ecnt);
    vec_t v;
    v.av = av; v.awn = awn; v.awd = awd;
    v.mv = mv; v.mwn = mwn; v.mwd = mwd;
    v.rn1 = rn1; v.rn2 = rn2;
    v.ear = ear; v.emr = emr; v.ecnt = ecnt;
    vecs.push_back(v);
  endtask

  // One clock cycle: drive, check combinational outputs, clock, check the write port.
  task automatic step(input logic av, input logic [AW-1:0] awn, input logic [DW-1:0] awd,
                      input logic mv, input logic [AW-1:0] mwn, input logic [DW-1:0] mwd,
                      input logic [AW-1:0] rn1, input logic [AW-1:0] rn2,
                      input int ear, input int emr, input int ecnt);
    logic          m_ar, m_mr, pop, h;
    logic [DW-1:0] d;
    ent_t          popped;
    ent_t          e;
    bus.alu_valid = av;  bus.alu_wn = awn; bus.alu_wd = awd;
    bus.mem_valid = mv;  bus.mem_wn = mwn; bus.mem_wd = mwd;
    bus.fwd_rn1   = rn1; bus.fwd_rn2 = rn2;
    #1;
    m_ar = (exp_q.size() < DEPTH);
    m_mr = av ? (exp_q.size() <= DEPTH - 2) : m_ar;
    chk("alu_ready", 64'(bus.alu_ready), 64'(m_ar));
    chk("mem_ready", 64'(bus.mem_ready), 64'(m_mr));
    if (ear >= 0) chk("alu_ready_vec", 64'(bus.alu_ready), 64'(ear));
    if (emr >= 0) chk("mem_ready_vec", 64'(bus.mem_ready), 64'(emr));
    model_fwd(rn1, h, d);
    chk("fwd_hit1", 64'(bus.fwd_hit1), 64'(h));
    chk("fwd_data1", 64'(bus.fwd_data1), 64'(d));
    model_fwd(rn2, h, d);
    chk("fwd_hit2", 64'(bus.fwd_hit2), 64'(h));
    chk("fwd_data2", 64'(bus.fwd_data2), 64'(d));
    pop = (exp_q.size() > 0);
    popped.wn = '0;
    popped.wd = '0;
    if (pop) popped = exp_q.pop_front();
    if (av && m_ar && (awn != '0)) begin
      e.wn = awn; e.wd = awd; exp_q.push_back(e);
    end
    if (mv && m_mr && (mwn != '0)) begin
      e.wn = mwn; e.wd = mwd; exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    chk("RegWrite", 64'(bus.RegWrite), 64'(pop));
    if (pop) begin
      chk("WN", 64'(bus.WN), 64'(popped.wn));
      chk("WD", 64'(bus.WD), 64'(popped.wd));
      last = popped;
    end
    last_rw = pop;
    chk("count", 64'(bus.count), 64'(exp_q.size()));
    if (ecnt >= 0) chk("count_vec", 64'(bus.count), 64'(ecnt));
    $display("txn %0d: alu v=%0b wn=%0d wd=0x%0h mem v=%0b wn=%0d wd=0x%0h -> RegWrite=%0b WN=%0d WD=0x%0h count=%0d",
             txn, av, awn, awd, mv, mwn, mwd, bus.RegWrite, bus.WN, bus.WD, bus.count);
    txn++;
  endtask

  task automatic idle(input logic [AW-1:0] rn1, input logic [AW-1:0] rn2);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, rn1, rn2, -1, -1, -1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.alu_valid = 1'b0;  bus.alu_wn = '0; bus.alu_wd = '0;
    bus.mem_valid = 1'b0;  bus.mem_wn = '0; bus.mem_wd = '0;
    bus.fwd_rn1   = 5'd5;  bus.fwd_rn2 = 5'd3;
    bus2.alu_valid = 1'b0; bus2.alu_wn = '0; bus2.alu_wd = '0;
    bus2.mem_valid = 1'b0; bus2.mem_wn = '0; bus2.mem_wd = '0;
    bus2.fwd_rn1   = '0;   bus2.fwd_rn2 = '0;

    // Vector table: single write, same-register pair, r0 discard, fill/back-pressure.
    add(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0,  5'd5, 5'd0, 1, 1, 1);
    add(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  5'd5, 5'd0, 1, 1, 0);
    add(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  5'd5, 5'd0, 1, 1, 0);
    add(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  5'd5, 5'd0, 1, 1, 0);
    add(1'b1, 5'd3, 32'hA,    1'b1, 5'd3, 32'hB,  5'd3, 5'd5, 1, 1, 2);
    add(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  5'd3, 5'd5, 1, 1, 1);
    add(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  5'd3, 5'd5, 1, 1, 0);
    add(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  5'd3, 5'd5, 1, 1, 0);
    add(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd7, 32'h55, 5'd0, 5'd7, 1, 1, 1);
    add(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  5'd0, 5'd7, 1, 1, 0);
    add(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  5'd0, 5'd7, 1, 1, 0);
    add(1'b1, 5'd1, 32'h11,   1'b1, 5'd2, 32'h22, 5'd9, 5'd2, 1, 1, 2);
    add(1'b1, 5'd4, 32'h44,   1'b1, 5'd6, 32'h66, 5'd9, 5'd2, 1, 1, 3);
    add(1'b1, 5'd8, 32'h88,   1'b1, 5'd9, 32'h99, 5'd9, 5'd2, 1, 0, 3);
    add(1'b1, 5'd10, 32'hAA,  1'b1, 5'd9, 32'h99, 5'd9, 5'd2, 1, 0, 3);
    add(1'b0, 5'd0, 32'h0,    1'b1, 5'd9, 32'h99, 5'd9, 5'd2, 1, 1, 3);
    add(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  5'd9, 5'd2, 1, 1, 2);
    add(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  5'd9, 5'd2, 1, 1, 1);
    add(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  5'd9, 5'd2, 1, 1, 0);
    add(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  5'd9, 5'd2, 1, 1, 0);

    // Reset state before any clock edge.
    #2;
    chk("rst_RegWrite", 64'(bus.RegWrite), 64'd0);
    chk("rst_WN", 64'(bus.WN), 64'd0);
    chk("rst_WD", 64'(bus.WD), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_alu_ready", 64'(bus.alu_ready), 64'd1);
    chk("rst_mem_ready", 64'(bus.mem_ready), 64'd1);
    chk("rst_fwd_hit1", 64'(bus.fwd_hit1), 64'd0);
    chk("rst_fwd_data1", 64'(bus.fwd_data1), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[i])
      step(vecs[i].av, vecs[i].awn, vecs[i].awd, vecs[i].mv, vecs[i].mwn, vecs[i].mwd,
           vecs[i].rn1, vecs[i].rn2, vecs[i].ear, vecs[i].emr, vecs[i].ecnt);

    // Asynchronous reset with three entries queued and a write in flight.
    step(1'b1, 5'd5, 32'h50, 1'b1, 5'd6, 32'h60, 5'd6, 5'd8, 1, 1, 2);
    step(1'b1, 5'd7, 32'h70, 1'b1, 5'd8, 32'h80, 5'd6, 5'd8, 1, 1, 3);
    bus.alu_valid = 1'b1;
    bus.mem_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_RegWrite", 64'(bus.RegWrite), 64'd0);
    chk("midrst_count", 64'(bus.count), 64'd0);
    chk("midrst_alu_ready", 64'(bus.alu_ready), 64'd1);
    chk("midrst_mem_ready", 64'(bus.mem_ready), 64'd1);
    chk("midrst_fwd_hit1", 64'(bus.fwd_hit1), 64'd0);
    chk("midrst_fwd_hit2", 64'(bus.fwd_hit2), 64'd0);
    exp_q.delete();
    last_rw = 1'b0;
    @(posedge clk);
    #1;
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    rst = 1'b0;
    idle(5'd6, 5'd8);

    // Ten single writes with idle gaps; tail walks past the end twice.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 5'((i % 15) + 1), 32'hC0DE_0000 + 32'(i), 1'b0, 5'd0, 32'h0,
           5'((i % 15) + 1), 5'(((i + 14) % 15) + 1), 1, 1, -1);
      if (i % 2 == 1) idle(5'((i % 15) + 1), 5'd0);
    end
    idle(5'd10, 5'd9);
    idle(5'd10, 5'd9);
    idle(5'd10, 5'd9);

    // Two-deep queue reaches full: no admit on the popping edge.
    bus2.alu_valid = 1'b1; bus2.alu_wn = 5'd1; bus2.alu_wd = 32'h10;
    bus2.mem_valid = 1'b1; bus2.mem_wn = 5'd2; bus2.mem_wd = 32'h20;
    bus2.fwd_rn1   = 5'd2;
    #1;
    chk("d2_alu_ready_empty", 64'(bus2.alu_ready), 64'd1);
    chk("d2_mem_ready_empty", 64'(bus2.mem_ready), 64'd1);
    @(posedge clk); #1;
    chk("d2_count_full", 64'(bus2.count), 64'd2);
    chk("d2_RegWrite_0", 64'(bus2.RegWrite), 64'd0);
    bus2.alu_wn = 5'd3; bus2.alu_wd = 32'h30;
    bus2.mem_wn = 5'd4; bus2.mem_wd = 32'h40;
    #1;
    chk("d2_alu_ready_full", 64'(bus2.alu_ready), 64'd0);
    chk("d2_mem_ready_full", 64'(bus2.mem_ready), 64'd0);
    chk("d2_fwd_hit1", 64'(bus2.fwd_hit1), 64'd1);
    chk("d2_fwd_data1", 64'(bus2.fwd_data1), 64'h20);
    @(posedge clk); #1;
    chk("d2_count_after_full", 64'(bus2.count), 64'd1);
    chk("d2_WN_1", 64'(bus2.WN), 64'd1);
    chk("d2_WD_1", 64'(bus2.WD), 64'h10);
    #1;
    chk("d2_alu_ready_one", 64'(bus2.alu_ready), 64'd1);
    chk("d2_mem_ready_one", 64'(bus2.mem_ready), 64'd0);
    @(posedge clk); #1;
    chk("d2_count_2", 64'(bus2.count), 64'd1);
    chk("d2_WN_2", 64'(bus2.WN), 64'd2);
    bus2.alu_valid = 1'b0;
    #1;
    chk("d2_mem_ready_alone", 64'(bus2.mem_ready), 64'd1);
    @(posedge clk); #1;
    bus2.mem_valid = 1'b0;
    chk("d2_WN_3", 64'(bus2.WN), 64'd3);
    chk("d2_WD_3", 64'(bus2.WD), 64'h30);
    @(posedge clk); #1;
    chk("d2_WN_4", 64'(bus2.WN), 64'd4);
    chk("d2_WD_4", 64'(bus2.WD), 64'h40);
    chk("d2_count_0", 64'(bus2.count), 64'd0);
    @(posedge clk); #1;
    chk("d2_RegWrite_idle", 64'(bus2.RegWrite), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
